// File: rtl/dm_if.sv
// ----------------------------------------------------------------------------
// dm_if -- M/W-stage data memory bus.
//
// Signals:
//   Addr     [31:0]  byte address from the M-stage ALU (only [11:0] decoded)
//   WD       [31:0]  store data, unshifted rt value
//   Bit_Type [3:0]   byte-write enables from the byte-type decoder
//   Instr_M  [31:0]  M-stage instruction; [31:26] selects the load type
//   RD_W     [31:0]  W-stage load data, already extended
//   Busy             memory clear sweep in progress; pipeline must stall
//
// Modports:
//   master  -- pipeline side (drives address/data/enables, receives RD_W/Busy)
//   slave   -- memory side
// ----------------------------------------------------------------------------
interface dm_if;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [3:0]  Bit_Type;
    logic [31:0] Instr_M;
    logic [31:0] RD_W;
    logic        Busy;

    modport master (
        output Addr,
        output WD,
        output Bit_Type,
        output Instr_M,
        input  RD_W,
        input  Busy
    );

    modport slave (
        input  Addr,
        input  WD,
        input  Bit_Type,
        input  Instr_M,
        output RD_W,
        output Busy
    );
endinterface

// File: rtl/dm.sv
// ----------------------------------------------------------------------------
// dm -- 4 KiB data memory (1024 x 32) with byte-lane writes, a registered
// read into the W stage and load-type extension on the W side.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    dm_if.slave (Addr, WD, Bit_Type, Instr_M in; RD_W, Busy out)
//
// Build option:
//   DM_CLEAR_EN  when defined, every reset starts a 1024-cycle sweep that
//                zeroes the whole array while Busy is high. When undefined
//                the sweep controller is not built, Busy is tied low and the
//                array is left untouched by reset.
// ----------------------------------------------------------------------------
module dm (
    input  logic clk,
    input  logic reset,
    dm_if.slave  bus
);

    localparam int DATA_W  = 32;
    localparam int DEPTH_W = 10;
    localparam int DEPTH   = 1 << DEPTH_W;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Address bits above [11:2] are intentionally ignored: out-of-range
    // addresses alias into the array, range checking lives in the decoder.
    logic              unused_bus_bits;
    assign unused_bus_bits = ^{bus.Addr[31:12], bus.Instr_M[25:0]};

    logic [DEPTH_W-1:0] idx_p0;
    logic [DATA_W-1:0]  lane_data_p0;
    logic [3:0]         lane_we_p0;

    logic [DEPTH_W-1:0] wr_addr_p0;
    logic [DATA_W-1:0]  wr_data_p0;
    logic [3:0]         wr_we_p0;

    logic               busy;
    logic               clr_we;
    logic [DEPTH_W-1:0] clr_addr;

    logic [DATA_W-1:0]  word_p1;
    logic [5:0]         op_p1;
    logic [1:0]         off_p1;

    assign idx_p0 = bus.Addr[11:2];

    // ------------------------------------------------------------------
    // Load extension helpers (little-endian lanes: byte n = word[8n+7:8n])
    // ------------------------------------------------------------------
    function automatic logic [7:0] pick_byte(input logic [31:0] w,
                                             input logic [1:0]  off);
        return w[8*off +: 8];
    endfunction

    function automatic logic [15:0] pick_half(input logic [31:0] w,
                                              input logic        hi);
        return hi ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] sext8(input logic signed [7:0] b);
        logic signed [31:0] r;
        r = 32'(b);
        return r;
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] h);
        logic signed [31:0] r;
        r = 32'(h);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: byte-lane decode of the store request
    // ------------------------------------------------------------------
    always_comb begin
        lane_data_p0 = '0;
        lane_we_p0   = '0;
        case (bus.Bit_Type)
            4'b1111: begin
                lane_data_p0 = bus.WD;
                lane_we_p0   = 4'b1111;
            end
            4'b0011, 4'b1100: begin
                lane_data_p0 = {bus.WD[15:0], bus.WD[15:0]};
                lane_we_p0   = bus.Bit_Type;
            end
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                lane_data_p0 = {4{bus.WD[7:0]}};
                lane_we_p0   = bus.Bit_Type;
            end
            // Non-contiguous or three-lane patterns are not legal stores.
            default: begin
                lane_data_p0 = '0;
                lane_we_p0   = '0;
            end
        endcase
    end

`ifdef DM_CLEAR_EN
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [DEPTH_W-1:0] ptr;
    logic [DEPTH_W-1:0] ptr_nx;

    // Reset always (re)starts the sweep from word 0, even mid-sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = ptr;
        case (state)
            IDLE: begin
                state_nx = IDLE;
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                ptr_nx = ptr + 10'd1;
                if (ptr == '1) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // The sweep owns the write port; pipeline stores are dropped while busy.
    always_comb begin
        wr_addr_p0 = idx_p0;
        wr_data_p0 = lane_data_p0;
        wr_we_p0   = busy ? 4'b0000 : lane_we_p0;
        if (clr_we) begin
            wr_addr_p0 = clr_addr;
            wr_data_p0 = '0;
            wr_we_p0   = 4'b1111;
        end
    end

    // ------------------------------------------------------------------
    // Stage p0 -> p1: array write and registered read (read sees the
    // contents before this edge's write)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_we_p0[k]) begin
                mem[wr_addr_p0][8*k +: 8] <= wr_data_p0[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || busy) begin
            word_p1 <= '0;
            op_p1   <= '0;
            off_p1  <= '0;
        end else begin
            word_p1 <= mem[idx_p0];
            op_p1   <= bus.Instr_M[31:26];
            off_p1  <= bus.Addr[1:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: W-side load extension
    // ------------------------------------------------------------------
    always_comb begin
        bus.RD_W = word_p1;
        case (op_p1)
            OP_LB:   bus.RD_W = sext8(pick_byte(word_p1, off_p1));
            OP_LBU:  bus.RD_W = {24'h0, pick_byte(word_p1, off_p1)};
            OP_LH:   bus.RD_W = sext16(pick_half(word_p1, off_p1[1]));
            OP_LHU:  bus.RD_W = {16'h0, pick_half(word_p1, off_p1[1])};
            default: bus.RD_W = word_p1;
        endcase
    end

    assign bus.Busy = busy;

endmodule

// File: tb/tb_dm.sv
// ----------------------------------------------------------------------------
// tb_dm -- self-checking bench for dm.
// Loads push their expected RD_W into a scoreboard queue when driven; a
// monitor pops one entry per driven operation just after the capturing edge.
// Sweep-specific checks are compiled when DM_CLEAR_EN is defined.
// ----------------------------------------------------------------------------
module tb_dm;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    sb_t  q[$];

    dm_if bus ();

    dm u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Monitor: result of the op captured at this edge is visible on RD_W.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) check(e.tag, bus.RD_W, e.exp);
        end
    end

    task automatic op(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] bt, input logic [5:0] opc,
                      input bit c, input logic [31:0] e, input string tag);
        sb_t s;
        bus.Addr     = a;
        bus.WD       = wd;
        bus.Bit_Type = bt;
        bus.Instr_M  = {opc, 26'h0};
        s.chk = c;
        s.exp = e;
        s.tag = tag;
        q.push_back(s);
        @(negedge clk);
        bus.Bit_Type = 4'b0000;
        bus.Instr_M  = 32'h0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] bt, input logic [5:0] opc);
        op(a, wd, bt, opc, 1'b0, 32'h0, "");
    endtask

    task automatic ld(input logic [31:0] a, input logic [5:0] opc,
                      input logic [31:0] e, input string tag);
        op(a, 32'h0, 4'b0000, opc, 1'b1, e, tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef DM_CLEAR_EN
    // Counts negedges with Busy high, starting from the current one.
    task automatic count_busy(input int start, output int n);
        n = start;
        while (bus.Busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mdl [16];
        logic [31:0] a, wd, v, e;
        logic [3:0]  bt;
        int unsigned wi, off, kind;
        int          n;

        clk          = 1'b0;
        reset        = 1'b0;
        n_chk        = 0;
        n_err        = 0;
        bus.Addr     = 32'h0;
        bus.WD       = 32'h0;
        bus.Bit_Type = 4'b0000;
        bus.Instr_M  = 32'h0;

        @(negedge clk);
        do_reset();
        check("rst_rdw", bus.RD_W, 32'h0);

`ifdef DM_CLEAR_EN
        check("rst_busy", {31'h0, bus.Busy}, 32'h1);
        count_busy(0, n);
        check("sweep_len", n, 1024);
        ld(32'h000, OP_LW, 32'h0, "clr_lw_000");
        ld(32'hFFC, OP_LW, 32'h0, "clr_lw_ffc");
`else
        check("rst_busy", {31'h0, bus.Busy}, 32'h0);
`endif

        // Word store then every load flavour
        st(32'h010, 32'h8765_4321, 4'b1111, OP_SW);
        ld(32'h013, OP_LB,  32'hFFFF_FF87, "lb_013");
        ld(32'h013, OP_LBU, 32'h0000_0087, "lbu_013");
        ld(32'h012, OP_LH,  32'hFFFF_8765, "lh_012");
        ld(32'h010, OP_LHU, 32'h0000_4321, "lhu_010");
        ld(32'h010, OP_LB,  32'h0000_0021, "lb_010");
        ld(32'h010, OP_LW,  32'h8765_4321, "lw_010");
        ld(32'h010, OP_SW,  32'h8765_4321, "raw_other_op");

        // Partial-word stores
        st(32'h020, 32'h1122_3344, 4'b1111, OP_SW);
        st(32'h021, 32'h0000_00AA, 4'b0010, OP_SB);
        ld(32'h020, OP_LW,  32'h1122_AA44, "sb_021");
        ld(32'h021, OP_LB,  32'hFFFF_FFAA, "lb_021");
        st(32'h022, 32'h0000_BEEF, 4'b1100, OP_SH);
        ld(32'h020, OP_LW,  32'hBEEF_AA44, "sh_022");
        ld(32'h022, OP_LHU, 32'h0000_BEEF, "lhu_022");
        ld(32'h020, OP_LH,  32'hFFFF_AA44, "lh_020");

        // One-hot lanes 0 and 3
        st(32'h060, 32'h0000_0000, 4'b1111, OP_SW);
        st(32'h060, 32'h1234_5677, 4'b0001, OP_SB);
        ld(32'h060, OP_LW,  32'h0000_0077, "sb_060");
        st(32'h063, 32'h0000_00C3, 4'b1000, OP_SB);
        ld(32'h060, OP_LW,  32'hC300_0077, "sb_063");
        ld(32'h063, OP_LB,  32'hFFFF_FFC3, "lb_063");

        // Illegal / empty enables leave the word alone
        st(32'h030, 32'h5A5A_1234, 4'b1111, OP_SW);
        st(32'h030, 32'hFFFF_FFFF, 4'b0000, OP_SW);
        st(32'h030, 32'hFFFF_FFFF, 4'b0101, OP_SW);
        st(32'h030, 32'hFFFF_FFFF, 4'b0111, OP_SW);
        ld(32'h030, OP_LW,  32'h5A5A_1234, "bt_illegal");

        // Read returns pre-write contents when load and store share an edge
        st(32'h040, 32'h0123_4567, 4'b1111, OP_SW);
        op(32'h040, 32'h89AB_CDEF, 4'b1111, OP_LW, 1'b1, 32'h0123_4567, "rbw_old");
        ld(32'h040, OP_LW,  32'h89AB_CDEF, "rbw_new");

        // High address bits alias
        st(32'hFFF0_0050, 32'h5555_AAAA, 4'b1111, OP_SW);
        ld(32'h0000_0050, OP_LW, 32'h5555_AAAA, "alias_lo");
        ld(32'h0000_1050, OP_LW, 32'h5555_AAAA, "alias_hi");

        // Randomised traffic against a word-level model
        for (int i = 0; i < 16; i++) begin
            mdl[i] = $urandom;
            st(32'h100 + 32'(4 * i), mdl[i], 4'b1111, OP_SW);
        end
        for (int i = 0; i < 60; i++) begin
            wi   = $urandom_range(0, 15);
            off  = $urandom_range(0, 3);
            kind = $urandom_range(0, 6);
            wd   = $urandom;
            a    = 32'h100 + 32'(4 * wi) + 32'(off);
            case (kind)
                0: begin
                    mdl[wi] = wd;
                    st(a, wd, 4'b1111, OP_SW);
                end
                1: begin
                    if (off >= 2) begin
                        mdl[wi][31:16] = wd[15:0];
                        bt = 4'b1100;
                    end else begin
                        mdl[wi][15:0] = wd[15:0];
                        bt = 4'b0011;
                    end
                    st(a, wd, bt, OP_SH);
                end
                2: begin
                    mdl[wi][8*off +: 8] = wd[7:0];
                    bt = 4'b0001 << off;
                    st(a, wd, bt, OP_SB);
                end
                3: begin
                    v = mdl[wi] >> (8 * off);
                    e = {{24{v[7]}}, v[7:0]};
                    ld(a, OP_LB, e, "rnd_lb");
                end
                4: begin
                    v = mdl[wi] >> (8 * off);
                    ld(a, OP_LBU, {24'h0, v[7:0]}, "rnd_lbu");
                end
                5: begin
                    v = (off >= 2) ? (mdl[wi] >> 16) : mdl[wi];
                    ld(a, OP_LH, {{16{v[15]}}, v[15:0]}, "rnd_lh");
                    ld(a, OP_LHU, {16'h0, v[15:0]}, "rnd_lhu");
                end
                default: begin
                    ld(a, OP_LW, mdl[wi], "rnd_lw");
                end
            endcase
        end

`ifdef DM_CLEAR_EN
        // Reset mid-sweep restarts it; stores during the sweep are lost
        st(32'h000, 32'hDEAD_BEEF, 4'b1111, OP_SW);
        st(32'hFFC, 32'hCAFE_F00D, 4'b1111, OP_SW);
        st(32'h070, 32'h7777_7777, 4'b1111, OP_SW);
        do_reset();
        repeat (500) @(negedge clk);
        check("busy_at_500", {31'h0, bus.Busy}, 32'h1);
        do_reset();
        check("busy_restart", {31'h0, bus.Busy}, 32'h1);
        st(32'h070, 32'h1234_5678, 4'b1111, OP_SW);
        ld(32'h070, OP_LW, 32'h0, "rdw_while_busy");
        count_busy(2, n);
        check("sweep_restart_len", n, 1024);
        ld(32'h000, OP_LW, 32'h0, "swept_000");
        ld(32'hFFC, OP_LW, 32'h0, "swept_ffc");
        ld(32'h070, OP_LW, 32'h0, "busy_store_dropped");
`else
        // Reset leaves memory contents alone
        st(32'h080, 32'hCAFE_F00D, 4'b1111, OP_SW);
        do_reset();
        check("rst2_rdw", bus.RD_W, 32'h0);
        ld(32'h080, OP_LW, 32'hCAFE_F00D, "rst_keeps_mem");
`endif

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dm.md
DM -- requirements
Module: dm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state updates on rising edge); reset input 1 (synchronous, active-high).
REQ-002 Addr  input  32  byte address from M-stage ALU; only Addr[11:0] used.
REQ-003 WD  input  32  M-stage store data (rt value, unshifted).
REQ-004 Bit_Type  input  4  byte-write enables from the byte-type decoder; 4'b0000 means no write.
REQ-005 Instr_M  input  32  M-stage instruction; Instr_M[31:26] selects load type.
REQ-006 RD_W  output  32  W-stage load data, extended per load type.
REQ-007 Busy  output  1  high while memory clear sweep runs; pipeline stalls on it.

Function
REQ-008 Storage SHALL be 1024 x 32-bit words indexed by Addr[11:2].
REQ-009 Write SHALL occur at rising clk when Busy=0; byte lane k written iff Bit_Type[k]=1.
REQ-010 Lane data SHALL be: 4'b1111 -> WD; 4'b0011/4'b1100 -> {WD[15:0],WD[15:0]}; one-hot -> {4{WD[7:0]}}; any other pattern -> no write.
REQ-011 Read SHALL be registered, latency 1: at rising clk, word at Addr[11:2] (pre-write contents), Instr_M[31:26] and Addr[1:0] captured into W registers.
REQ-012 RD_W SHALL be combinational from W registers: lb 100000 sign-extended byte at offset; lbu 100100 zero-extended byte; lh 100001 sign-extended half (offset[1]=1 -> [31:16], else [15:0]); lhu 100101 zero-extended half; all other opcodes incl. lw 100011 -> raw word.
REQ-013 Byte at offset n SHALL be word[8n+7:8n] (little-endian lanes, matching Bit_Type one-hot).
REQ-014 Controller SHALL have states IDLE and CLEAR; CLEAR -> IDLE after the cycle writing word 1023; IDLE only left via reset.
REQ-015 In CLEAR: each cycle write 32'h0 to word ptr, ptr increments by 1 (10-bit), Busy=1, Bit_Type writes ignored, W registers load 0.
REQ-016 Busy SHALL be exactly 1 in CLEAR and 0 in IDLE.
REQ-017 Out-of-range addresses (Addr[31:12]!=0) SHALL alias into Addr[11:2]; range checking is the decoder's job.

Reset
REQ-018 On reset: W data, opcode and offset registers 0 (RD_W=32'h0), ptr=0.
REQ-019 With DM_CLEAR_EN defined, reset SHALL enter CLEAR (Busy=1 from the cycle after reset); without it, IDLE (Busy=0).
REQ-020 Reset asserted mid-sweep SHALL restart the sweep at ptr=0.
REQ-021 Without DM_CLEAR_EN, reset SHALL not alter memory contents.

Configuration
REQ-022 Macro DM_CLEAR_EN: defined -> CLEAR state, ptr and sweep logic compiled in, 1024-cycle zeroing after every reset; undefined -> logic removed, Busy tied 0, memory contents undefined until written.

Verification
REQ-023 DM_CLEAR_EN defined, reset 1 cycle -> Busy=1 for exactly 1024 cycles; afterwards lw from 0x000 and 0xFFC -> RD_W=32'h0.
REQ-024 sw WD=32'h8765_4321 at 0x010 (Bit_Type 1111); next cycle lb 0x013 -> RD_W=32'hFFFF_FF87; lbu 0x013 -> 32'h0000_0087; lh 0x012 -> 32'hFFFF_8765; lhu 0x010 -> 32'h0000_4321.
REQ-025 Word 0x020 = 32'h1122_3344; sb WD=32'h0000_00AA at 0x021 (0010) -> lw 0x020 returns 32'h1122_AA44; sh WD=32'h0000_BEEF at 0x022 (1100) -> 32'hBEEF_AA44.
REQ-026 Bit_Type=0000 with WD=32'hFFFF_FFFF at 0x030 -> word unchanged; Bit_Type 0101 -> word unchanged.
REQ-027 Reset asserted at sweep cycle 500 -> Busy stays 1 for 1024 further cycles; store issued while Busy=1 -> target word reads 0 after sweep.
